// File: rtl/comparador_serial_id.sv
// Bit-serial magnitude comparator, MSB first, unsigned or two's-complement.
// A two-flop (m,n) chain carries the equal/greater/less decision across bits.
module comparador_serial_id #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic            sgn_q, sgn_d;
  logic            m_q, m_d, n_q, n_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

  logic ai, bi, m_upd, n_upd;

  always_comb begin
    ai = a_q[idx_q];
    bi = b_q[idx_q];
    // Swapping the sign bits turns an unsigned compare into a signed one.
    if (sgn_q && (idx_q == IdxMsb)) begin
      ai = b_q[idx_q];
      bi = a_q[idx_q];
    end
    m_upd = ~n_q | (m_q & (ai | ~bi));
    n_upd = ~m_q | (n_q & (~ai | bi));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    m_d     = m_q;
    n_d     = n_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = signed_mode;
          m_d     = 1'b1;
          n_d     = 1'b1;
          idx_d   = IdxMsb;
          state_d = StScan;
        end
      end
      StScan: begin
        m_d = m_upd;
        n_d = n_upd;
        if ((idx_q == '0) || ((EARLY_EXIT != 0) && !(m_upd && n_upd))) begin
          gt_d    = m_upd & ~n_upd;
          lt_d    = ~m_upd & n_upd;
          eq_d    = m_upd & n_upd;
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      m_q     <= 1'b1;
      n_q     <= 1'b1;
      idx_q   <= IdxMsb;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      m_q     <= m_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy = (state_q == StScan);
  assign done = (state_q == StDone);
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_comparador_serial_id.sv
// Directed bench: one early-exit and one full-scan comparator share the same stimulus.
module tb_comparador_serial_id;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       signed_mode = 1'b0;
  logic       busy, done, gt, lt, eq;
  logic       busy_f, done_f, gt_f, lt_f, eq_f;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] prev_res = 3'b000;

  always #5 clk = ~clk;

  comparador_serial_id #(.WIDTH(8), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq)
  );

  comparador_serial_id #(.WIDTH(8), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy_f), .done(done_f), .gt(gt_f), .lt(lt_f), .eq(eq_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // exp_res is {gt,lt,eq}; the full-scan instance always needs 8 edges.
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic sv, input logic [2:0] exp_res, input int exp_lat,
                         input bit disturb);
    int lat1, lat2, np1, np2;
    logic [2:0] r1, r2;
    lat1 = 0; lat2 = 0; np1 = 0; np2 = 0; r1 = '0; r2 = '0;
    @(negedge clk);
    a = av; b = bv; signed_mode = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_hold"}, 32'({gt, lt, eq}), 32'(prev_res));
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done) begin
        np1++;
        if (lat1 == 0) begin
          lat1 = n;
          r1 = {gt, lt, eq};
          check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        end
      end
      if (done_f) begin
        np2++;
        if (lat2 == 0) begin
          lat2 = n;
          r2 = {gt_f, lt_f, eq_f};
        end
      end
      if (disturb && n == 2) begin
        a = 8'hFF; b = 8'h00; signed_mode = 1'b1; start = 1'b1;
      end
      if (disturb && n == 3) start = 1'b0;
    end
    check({tag, "_res"}, 32'(r1), 32'(exp_res));
    check({tag, "_lat"}, 32'(lat1), 32'(exp_lat));
    check({tag, "_pulses"}, 32'(np1), 32'd1);
    check({tag, "_res_full"}, 32'(r2), 32'(exp_res));
    check({tag, "_lat_full"}, 32'(lat2), 32'd8);
    check({tag, "_pulses_full"}, 32'(np2), 32'd1);
    check({tag, "_held"}, 32'({gt, lt, eq}), 32'(exp_res));
    prev_res = exp_res;
  endtask

  initial begin
    #1;
    check("rst_outs", 32'({busy, done, gt, lt, eq}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_cmp("eq_a5",    8'hA5, 8'hA5, 1'b0, 3'b001, 8, 1'b0);
    run_cmp("u_80_7f",  8'h80, 8'h7F, 1'b0, 3'b100, 1, 1'b0);
    run_cmp("s_80_7f",  8'h80, 8'h7F, 1'b1, 3'b010, 1, 1'b0);
    run_cmp("s_ff_fe",  8'hFF, 8'hFE, 1'b1, 3'b100, 8, 1'b0);
    run_cmp("s_7f_80",  8'h7F, 8'h80, 1'b1, 3'b100, 1, 1'b0);
    run_cmp("u_12_13",  8'h12, 8'h13, 1'b0, 3'b010, 8, 1'b1);

    // Abort a scan at its third edge; outputs must clear without a clock.
    @(negedge clk);
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outs", 32'({busy, done, gt, lt, eq}), 32'd0);
    check("abort_outs_full", 32'({busy_f, done_f, gt_f, lt_f, eq_f}), 32'd0);
    begin
      int pulses;
      pulses = 0;
      for (int n = 0; n < 4; n++) begin
        @(negedge clk);
        if (done || done_f) pulses++;
      end
      rst_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        if (done || done_f || busy) pulses++;
      end
      check("abort_no_done", 32'(pulses), 32'd0);
    end
    prev_res = 3'b000;

    run_cmp("u_03_01",  8'h03, 8'h01, 1'b0, 3'b100, 7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
